// File: rtl/uart_rx_ctrl.sv
// Receive-side frame sequencer: detects the start edge, runs the oversample and
// bit counters, enables the checkers and issues one verdict pulse per frame.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  par_err_out,
    output logic                  frm_err_out
);

    // state  | meaning
    // IDLE   | line idle, waiting for a low level on rx_in
    // START  | start bit, start checker enabled
    // DATA   | data bits, one deserializer strobe per bit
    // PARITY | parity bit, parity verdict captured at the check edge
    // STOP   | stop bit, leaves at the check edge
    // DONE   | single cycle, issues the frame verdict pulse
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] edge_nxt;
    logic [3:0]            bit_nxt;
    logic [PRESCALE_W-1:0] pre_q, pre_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_flag, par_flag_nxt;
    logic                  frm_flag, frm_flag_nxt;
    logic [PRESCALE_W-1:0] chk_edge, last_edge;
    logic                  at_chk, at_end;

    assign chk_edge  = (pre_q >> 1) + PRESCALE_W'(2);
    assign last_edge = pre_q - PRESCALE_W'(1);
    assign at_chk    = (edge_cnt == chk_edge);
    assign at_end    = (edge_cnt == last_edge);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            pre_q    <= '0;
            par_en_q <= 1'b0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            edge_cnt <= edge_nxt;
            bit_cnt  <= bit_nxt;
            pre_q    <= pre_nxt;
            par_en_q <= par_en_nxt;
            par_flag <= par_flag_nxt;
            frm_flag <= frm_flag_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        edge_nxt     = edge_cnt;
        bit_nxt      = bit_cnt;
        pre_nxt      = pre_q;
        par_en_nxt   = par_en_q;
        par_flag_nxt = par_flag;
        frm_flag_nxt = frm_flag;
        dat_samp_en  = 1'b0;
        deser_en     = 1'b0;
        strt_chk_en  = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;
        data_valid   = 1'b0;
        par_err_out  = 1'b0;
        frm_err_out  = 1'b0;

        // Counters free-run inside a frame; individual states override on exit.
        if (state != IDLE && state != DONE) begin
            dat_samp_en = 1'b1;
            if (at_end) begin
                edge_nxt = '0;
                bit_nxt  = bit_cnt + 4'd1;
            end else begin
                edge_nxt = edge_cnt + PRESCALE_W'(1);
            end
        end

        case (state)
            IDLE: begin
                edge_nxt = '0;
                bit_nxt  = '0;
                if (!rx_in) begin
                    state_nxt  = START;
                    edge_nxt   = PRESCALE_W'(1);
                    pre_nxt    = prescale;
                    par_en_nxt = par_en;
                end
            end
            START: begin
                strt_chk_en = 1'b1;
                if (at_chk && strt_glitch) begin
                    state_nxt = IDLE;
                    edge_nxt  = '0;
                    bit_nxt   = '0;
                end else if (at_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                deser_en = at_chk;
                if (at_end && bit_cnt == 4'(DATA_WIDTH))
                    state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_chk_en = 1'b1;
                if (at_chk)
                    par_flag_nxt = par_err;
                if (at_end)
                    state_nxt = STOP;
            end
            STOP: begin
                stp_chk_en = 1'b1;
                // Leave early so a following start bit is never missed.
                if (at_chk) begin
                    frm_flag_nxt = stp_err;
                    state_nxt    = DONE;
                    edge_nxt     = '0;
                    bit_nxt      = '0;
                end
            end
            DONE: begin
                edge_nxt = '0;
                bit_nxt  = '0;
                if (frm_flag)
                    frm_err_out = 1'b1;
                else if (par_flag)
                    par_err_out = 1'b1;
                else
                    data_valid = 1'b1;
                par_flag_nxt = 1'b0;
                frm_flag_nxt = 1'b0;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                edge_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are described by start cycle and
// prescale, and expected strobes, pulses and counter values follow from arithmetic.
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic          data_valid, par_err_out, frm_err_out;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .par_err_out(par_err_out),
        .frm_err_out(frm_err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event kinds: 0 deser strobe, 1 data_valid, 2 par_err_out, 3 frm_err_out
    typedef struct {int kind; int at;} ev_t;
    typedef struct {int t0; int p; int par; int last; int done;} fr_t;
    ev_t ev_q[$];
    fr_t fr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pack_state(int e, int b, int samp, int strt, int par, int stp);
        return (e << 8) | (b << 4) | (samp << 3) | (strt << 2) | (par << 1) | stp;
    endfunction

    function automatic int rand_pre();
        return 8 << $urandom_range(0, 2);
    endfunction

    always @(negedge clk) begin : monitor
        int c, n, b, e, exp_v, act_v;
        logic [3:0] obs;
        ev_t ev;
        if (rst) begin
            c = cyc;
            while (fr_q.size() > 0 && fr_q[0].done < c) void'(fr_q.pop_front());
            exp_v = 0;
            if (fr_q.size() > 0 && c > fr_q[0].t0 && c <= fr_q[0].last) begin
                n = c - fr_q[0].t0;
                b = n / fr_q[0].p;
                e = n % fr_q[0].p;
                exp_v = pack_state(e, b, 1, int'(b == 0),
                                   int'(fr_q[0].par != 0 && b == DW + 1),
                                   int'(b == DW + 1 + fr_q[0].par));
            end
            act_v = pack_state(int'(edge_cnt), int'(bit_cnt), int'(dat_samp_en),
                               int'(strt_chk_en), int'(par_chk_en), int'(stp_chk_en));
            check("frame_state", act_v, exp_v);
            check("pulse_onehot", int'(data_valid) + int'(par_err_out) + int'(frm_err_out) <= 1, 1);

            while (ev_q.size() > 0 && ev_q[0].at < c) begin
                ev = ev_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_event kind %0d: expected at cycle %0d, not seen by cycle %0d",
                         ev.kind, ev.at, c);
            end
            obs = {frm_err_out, par_err_out, data_valid, deser_en};
            for (int k = 0; k < 4; k++) begin
                if (obs[k]) begin
                    if (ev_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event kind %0d at cycle %0d: got output, expected none",
                                 k, c);
                    end else begin
                        ev = ev_q.pop_front();
                        check("event_kind", k, ev.kind);
                        check("event_cycle", c, ev.at);
                    end
                end
            end
        end
    end

    task automatic idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            rx_in       = 1'b1;
            prescale    = PW'(rand_pre());
            par_en      = 1'($urandom);
            strt_glitch = 1'($urandom);
            par_err     = 1'($urandom);
            stp_err     = 1'($urandom);
        end
    endtask

    // err: 0 clean, 1 start glitch, 2 parity error, 3 stop error, 4 parity+stop error
    task automatic send_frame(input int p, input int par, input int err, input int data,
                              input int abort_bit);
        int t0, chk, stopb, last, done, len, b, kind, act;
        fr_t fr;
        ev_t ev;
        logic [7:0] d;
        d = 8'(data);
        @(posedge clk);
        #1;
        t0    = cyc;
        chk   = p / 2 + 2;
        stopb = DW + 1 + par;
        if (err == 1) begin
            last = t0 + chk;
            done = last;
            len  = chk + 1;
        end else begin
            last = t0 + p * stopb + chk;
            done = last + 1;
            len  = p * (stopb + 1);
        end
        fr.t0 = t0; fr.p = p; fr.par = par; fr.last = last; fr.done = done;
        fr_q.push_back(fr);
        if (err != 1) begin
            for (int bb = 1; bb <= DW; bb++) begin
                ev.kind = 0;
                ev.at   = t0 + p * bb + chk;
                ev_q.push_back(ev);
            end
            kind = (err == 0) ? 1 : (err == 2) ? 2 : 3;
            ev.kind = kind;
            ev.at   = done;
            ev_q.push_back(ev);
        end
        for (int n = 0; n < len; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            b = n / p;
            if (err == 1)               rx_in = (n < 3) ? 1'b0 : 1'b1;
            else if (b == 0)            rx_in = 1'b0;
            else if (b <= DW)           rx_in = d[b-1];
            else if (par && b == DW + 1) rx_in = ^d;
            else                        rx_in = 1'b1;
            prescale    = (n == 0) ? PW'(p) : PW'(rand_pre());
            par_en      = (n == 0) ? 1'(par) : 1'($urandom);
            strt_glitch = (n == chk) ? (err == 1) : 1'($urandom);
            par_err     = (par != 0 && n == p * (DW + 1) + chk) ? (err == 2 || err == 4)
                                                                 : 1'($urandom);
            stp_err     = (n == p * stopb + chk) ? (err == 3 || err == 4) : 1'($urandom);
            if (abort_bit > 0 && n == p * abort_bit + 3) begin
                #2 rst = 1'b0;
                #1;
                act = (int'(edge_cnt) << 12) | (int'(bit_cnt) << 8) |
                      ({dat_samp_en, deser_en, strt_chk_en, par_chk_en} << 4) |
                      {stp_chk_en, data_valid, par_err_out, frm_err_out};
                check("reset_mid_frame", act, 0);
                fr_q.delete();
                ev_q.delete();
                rx_in = 1'b1;
                @(posedge clk);
                #2 rst = 1'b1;
                return;
            end
        end
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p, par, err, act;
        #3;
        act = (int'(edge_cnt) << 12) | (int'(bit_cnt) << 8) |
              ({dat_samp_en, deser_en, strt_chk_en, par_chk_en} << 4) |
              {stp_chk_en, data_valid, par_err_out, frm_err_out};
        check("reset_state", act, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        idle(3);

        send_frame(8, 0, 0, 'hA5, 0);   // clean
        idle(2);
        send_frame(8, 1, 0, 'h3C, 0);   // parity, no error
        idle(1);
        send_frame(8, 1, 2, 'h5A, 0);   // parity error
        send_frame(8, 0, 3, 'hF0, 0);   // stop error
        idle(2);
        send_frame(8, 0, 1, 'h00, 0);   // start glitch
        idle(4);
        send_frame(16, 1, 0, 'h81, 0);  // back-to-back pair
        send_frame(16, 1, 0, 'h7E, 0);
        idle(2);
        send_frame(8, 0, 0, 'h55, 4);   // reset during bit 4
        idle(2);
        send_frame(8, 0, 0, 'hC3, 0);
        send_frame(32, 1, 4, 'h99, 0);  // parity and stop error together

        for (int i = 0; i < 40; i++) begin
            p   = rand_pre();
            par = int'($urandom_range(0, 1));
            err = int'($urandom_range(0, 4));
            if (par == 0 && (err == 2 || err == 4)) err = 0;
            send_frame(p, par, err, int'($urandom), 0);
            idle(int'($urandom_range(0, 4)));
        end

        idle(5);
        check("events_drained", ev_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
